// File: rtl/gfx_span_rasterizer.sv
// gfx_span_rasterizer: rect/point rasterizer emitting clipped, textured spans of up to lanes pixels per beat
module gfx_span_rasterizer #(
  parameter int point_width = 16,
  parameter int lanes = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic                   cmd_point_i,
  input  logic                   clipping_enable_i,
  input  logic                   texture_enable_i,
  input  logic [point_width-1:0] dest_x0_i,
  input  logic [point_width-1:0] dest_y0_i,
  input  logic [point_width-1:0] dest_x1_i,
  input  logic [point_width-1:0] dest_y1_i,
  input  logic [point_width-1:0] clip_x0_i,
  input  logic [point_width-1:0] clip_y0_i,
  input  logic [point_width-1:0] clip_x1_i,
  input  logic [point_width-1:0] clip_y1_i,
  input  logic [point_width-1:0] src_x0_i,
  input  logic [point_width-1:0] src_y0_i,
  output logic                   pix_valid_o,
  input  logic                   pix_ready_i,
  output logic [point_width-1:0] x_o,
  output logic [point_width-1:0] y_o,
  output logic [point_width-1:0] u_o,
  output logic [point_width-1:0] v_o,
  output logic [lanes-1:0]       lane_mask_o,
  output logic                   last_o,
  output logic                   ack_o
);
  localparam int w = point_width;
  localparam int ww = point_width + 2;
  // two guard bits keep clip bounds and cx+lanes free of overflow
  typedef logic signed [ww-1:0] coord_t;
  typedef enum logic [1:0] {IDLE, SETUP, EMIT, DONE} state_t;
  localparam coord_t one = coord_t'(1);
  localparam coord_t lanes_c = coord_t'(lanes);
  localparam coord_t half = coord_t'(2 ** (w - 1));
  state_t state, state_n;
  logic pt, clip_en, tex_en;
  logic [w-1:0] dx0, dy0, dx1, dy1, kx0, ky0, kx1, ky1, sx0, sy0;
  coord_t xs, xe, ye, cx, cy;
  coord_t ex0, ey0, ex1, ey1, wx0, wy0, wx1, wy1, xs_n, xe_n, ys_n, ye_n;
  logic emit, step_x, step_y;
  always_comb begin
    ex0 = coord_t'(signed'(dx0));
    ey0 = coord_t'(signed'(dy0));
    ex1 = pt ? ex0 + one : coord_t'(signed'(dx1));
    ey1 = pt ? ey0 + one : coord_t'(signed'(dy1));
    wx0 = clip_en ? coord_t'({2'b00, kx0}) : '0;
    wy0 = clip_en ? coord_t'({2'b00, ky0}) : '0;
    wx1 = clip_en ? coord_t'({2'b00, kx1}) : half;
    wy1 = clip_en ? coord_t'({2'b00, ky1}) : half;
    xs_n = ex0 > wx0 ? ex0 : wx0;
    ys_n = ey0 > wy0 ? ey0 : wy0;
    xe_n = ex1 < wx1 ? ex1 : wx1;
    ye_n = ey1 < wy1 ? ey1 : wy1;
    emit = state == EMIT;
    step_x = cx + lanes_c < xe;
    step_y = cy + one < ye;
    state_n = state == IDLE  ? (cmd_valid_i ? SETUP : IDLE)
            : state == SETUP ? ((xs_n >= xe_n || ys_n >= ye_n) ? DONE : EMIT)
            : state == EMIT  ? ((pix_ready_i && !step_x && !step_y) ? DONE : EMIT)
            : IDLE;
    cmd_ready_o = state == IDLE;
    ack_o = state == DONE;
    pix_valid_o = emit;
    last_o = emit && !step_x && !step_y;
    x_o = emit ? cx[w-1:0] : '0;
    y_o = emit ? cy[w-1:0] : '0;
    u_o = (emit && tex_en) ? sx0 + cx[w-1:0] - dx0 : '0;
    v_o = (emit && tex_en) ? sy0 + cy[w-1:0] - dy0 : '0;
    lane_mask_o = '0;
    for (int i = 0; i < lanes; i++) lane_mask_o[i] = emit && (cx + coord_t'(i) < xe);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cx <= '0;
      cy <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && cmd_valid_i) begin
        pt <= cmd_point_i;
        clip_en <= clipping_enable_i;
        tex_en <= texture_enable_i;
        dx0 <= dest_x0_i;
        dy0 <= dest_y0_i;
        dx1 <= dest_x1_i;
        dy1 <= dest_y1_i;
        kx0 <= clip_x0_i;
        ky0 <= clip_y0_i;
        kx1 <= clip_x1_i;
        ky1 <= clip_y1_i;
        sx0 <= src_x0_i;
        sy0 <= src_y0_i;
      end
      if (state == SETUP) begin
        xs <= xs_n;
        xe <= xe_n;
        ye <= ye_n;
        cx <= xs_n;
        cy <= ys_n;
      end else if (emit && pix_ready_i && step_x) begin
        cx <= cx + lanes_c;
      end else if (emit && pix_ready_i && step_y) begin
        cx <= xs;
        cy <= cy + one;
      end
    end
  end
endmodule

// File: tb/tb_gfx_span_rasterizer.sv
// tb_gfx_span_rasterizer: scoreboard bench with a pixel-level reference model of span rasterization
module tb_gfx_span_rasterizer;
  localparam int W = 16;
  localparam int L = 4;
  logic clk = 0, rst_i = 1;
  logic cmd_valid_i = 0, cmd_ready_o, cmd_point_i = 0, clipping_enable_i = 0, texture_enable_i = 0;
  logic [W-1:0] dest_x0_i = 0, dest_y0_i = 0, dest_x1_i = 0, dest_y1_i = 0;
  logic [W-1:0] clip_x0_i = 0, clip_y0_i = 0, clip_x1_i = 0, clip_y1_i = 0, src_x0_i = 0, src_y0_i = 0;
  logic pix_valid_o, pix_ready_i = 1, last_o, ack_o;
  logic [W-1:0] x_o, y_o, u_o, v_o;
  logic [L-1:0] lane_mask_o;
  typedef struct {bit ack; int x; int y; int u; int v; int mask; bit last;} exp_t;
  exp_t q[$];
  int checks = 0, failures = 0, ready_mode = 0;
  bit done = 0;

  gfx_span_rasterizer #(.point_width(W), .lanes(L)) dut (
    .clk_i(clk), .rst_i(rst_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_point_i(cmd_point_i), .clipping_enable_i(clipping_enable_i), .texture_enable_i(texture_enable_i),
    .dest_x0_i(dest_x0_i), .dest_y0_i(dest_y0_i), .dest_x1_i(dest_x1_i), .dest_y1_i(dest_y1_i),
    .clip_x0_i(clip_x0_i), .clip_y0_i(clip_y0_i), .clip_x1_i(clip_x1_i), .clip_y1_i(clip_y1_i),
    .src_x0_i(src_x0_i), .src_y0_i(src_y0_i), .pix_valid_o(pix_valid_o), .pix_ready_i(pix_ready_i),
    .x_o(x_o), .y_o(y_o), .u_o(u_o), .v_o(v_o), .lane_mask_o(lane_mask_o), .last_o(last_o), .ack_o(ack_o)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1 pix_ready_i = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
  end

  // reference: walk the clipped rectangle row by row in lane-sized steps
  task automatic push_model(input bit pt, ce, te, input int x0, y0, x1, y1, k0, l0, k1, l1, s0, t0);
    int ex1, ey1, xs, xe, ys, ye, m;
    exp_t e;
    ex1 = pt ? x0 + 1 : x1;
    ey1 = pt ? y0 + 1 : y1;
    xs = ce ? (x0 > k0 ? x0 : k0) : (x0 > 0 ? x0 : 0);
    ys = ce ? (y0 > l0 ? y0 : l0) : (y0 > 0 ? y0 : 0);
    xe = ce ? (ex1 < k1 ? ex1 : k1) : (ex1 < 32768 ? ex1 : 32768);
    ye = ce ? (ey1 < l1 ? ey1 : l1) : (ey1 < 32768 ? ey1 : 32768);
    for (int y = ys; y < ye && xs < xe; y++)
      for (int x = xs; x < xe; x += L) begin
        m = 0;
        for (int i = 0; i < L; i++) if (x + i < xe) m |= 1 << i;
        e.ack = 0; e.x = x; e.y = y; e.mask = m;
        e.u = te ? ((s0 + x - x0) & 16'hFFFF) : 0;
        e.v = te ? ((t0 + y - y0) & 16'hFFFF) : 0;
        e.last = (x + L >= xe) && (y == ye - 1);
        q.push_back(e);
      end
    e = '{ack: 1, x: 0, y: 0, u: 0, v: 0, mask: 0, last: 0};
    q.push_back(e);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready_o) begin
      @(posedge clk);
      #1 n++;
      if (n > 5000) begin
        $display("FAIL cmd_ready_timeout got 0 expected 1");
        $fatal(1, "timeout");
      end
    end
  endtask

  task automatic send(input bit pt, ce, te, input int x0, y0, x1, y1, k0, l0, k1, l1, s0, t0);
    wait_ready();
    cmd_point_i = pt; clipping_enable_i = ce; texture_enable_i = te;
    dest_x0_i = W'(x0); dest_y0_i = W'(y0); dest_x1_i = W'(x1); dest_y1_i = W'(y1);
    clip_x0_i = W'(k0); clip_y0_i = W'(l0); clip_x1_i = W'(k1); clip_y1_i = W'(l1);
    src_x0_i = W'(s0); src_y0_i = W'(t0);
    cmd_valid_i = 1;
    @(posedge clk);
    #1 cmd_valid_i = 0;
    push_model(pt, ce, te, x0, y0, x1, y1, k0, l0, k1, l1, s0, t0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_i = 0;
    send(0, 0, 0, 0, 0, 6, 2, 0, 0, 0, 0, 0, 0);
    send(0, 1, 1, -3, -3, 5, 2, 1, 0, 3, 10, 10, 20);
    ready_mode = 1;
    send(0, 0, 1, 0, 0, 6, 2, 0, 0, 0, 0, 100, 200);
    send(0, 1, 1, 0, 0, 13, 5, 0, 0, 100, 100, 7, 9);
    ready_mode = 0;
    send(0, 0, 0, 5, 5, 5, 9, 0, 0, 0, 0, 0, 0);
    send(1, 1, 0, 20, 0, 0, 0, 0, 0, 20, 10, 0, 0);
    send(1, 0, 0, -1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    send(1, 0, 1, 7, 3, 0, 0, 0, 0, 0, 0, 3, 4);
    send(0, 1, 1, 32760, -2, 32767, 1, 32760, 0, 65535, 65535, 65530, 65535);
    send(0, 0, 0, 32764, 0, 32767, 1, 0, 0, 0, 0, 0, 0);
    send(0, 0, 0, 0, 0, 6, 2, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_i = 1;
    @(posedge clk);
    #1 rst_i = 0;
    q.delete();
    for (int n = 0; n < 60; n++) begin
      int x0, y0;
      ready_mode = $urandom_range(0, 1);
      x0 = $urandom_range(0, 40) - 10;
      y0 = $urandom_range(0, 30) - 8;
      send($urandom_range(0, 3) == 0, $urandom_range(0, 1), $urandom_range(0, 1),
           x0, y0, x0 + $urandom_range(0, 20) - 3, y0 + $urandom_range(0, 10) - 2,
           $urandom_range(0, 20), $urandom_range(0, 10), $urandom_range(0, 40), $urandom_range(0, 25),
           $urandom_range(0, 65535), $urandom_range(0, 65535));
    end
    wait_ready();
    @(posedge clk);
    done = 1;
  end

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  initial begin
    int cd = 0;
    bit held = 0, ack_due = 0, rst_seen = 0;
    logic [4*W+L+1:0] snap;
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (rst_i) begin
        q.delete();
        cd = 0; held = 0; ack_due = 0; rst_seen = 1;
        continue;
      end
      if (rst_seen) begin
        rst_seen = 0;
        chk("rst_valid", pix_valid_o, 0);
        chk("rst_ready", cmd_ready_o, 1);
        chk("rst_ack", ack_o, 0);
        chk("rst_last", last_o, 0);
        chk("rst_outs", int'(x_o | y_o | u_o | v_o) | int'(lane_mask_o), 0);
      end
      if (cd > 0) begin
        cd--;
        if (cd == 1) chk("setup_idle", {pix_valid_o, ack_o, cmd_ready_o}, 0);
        else chk("first_evt", pix_valid_o ? 1 : ack_o ? 2 : 0, q.size() == 0 ? -1 : q[0].ack ? 2 : 1);
      end
      if (cmd_valid_i && cmd_ready_o) cd = 2;
      if (held) begin
        chk("hold_stable", int'(snap != {pix_valid_o, last_o, x_o, y_o, u_o, v_o, lane_mask_o}), 0);
        held = 0;
      end
      if (pix_valid_o && !pix_ready_i) begin
        held = 1;
        snap = {pix_valid_o, last_o, x_o, y_o, u_o, v_o, lane_mask_o};
      end
      if (ack_due) begin
        chk("ack_after_last", ack_o, 1);
        ack_due = 0;
      end
      if (pix_valid_o && pix_ready_i) begin
        chk("beat_expected", int'(q.size() > 0 && !q[0].ack), 1);
        chk("busy_ready", cmd_ready_o, 0);
        if (q.size() > 0 && !q[0].ack) begin
          e = q.pop_front();
          chk("x", int'(x_o), e.x);
          chk("y", int'(y_o), e.y);
          chk("u", int'(u_o), e.u);
          chk("v", int'(v_o), e.v);
          chk("mask", int'(lane_mask_o), e.mask);
          chk("last", last_o, e.last);
          ack_due = e.last;
        end
      end
      if (ack_o) begin
        chk("ack_expected", int'(q.size() > 0 && q[0].ack), 1);
        if (q.size() > 0 && q[0].ack) void'(q.pop_front());
      end
    end
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
